// File: rtl/tick_scheduler.sv
// Multi-channel periodic scheduler: per-channel tick dividers raise pending
// requests that are dispatched one at a time with round-robin arbitration.

module tick_sched_lane #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 tick_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 fire_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, lim;
    logic                 fire_q, fire_d;

    // >= rather than == so a ratio lowered below the running count fires at once
    always_comb begin
        lim    = (div_i == '0) ? '0 : div_i - 1'b1;
        fire_d = tick_i && en_i && (cnt_q >= lim);
        cnt_d  = cnt_q;
        if (!en_i)
            cnt_d = '0;
        else if (tick_i)
            cnt_d = fire_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fire_q <= fire_d;
        end
    end

    assign fire_o = fire_q;
endmodule

module tick_scheduler #(
    parameter int NB_CHANNELS = 4,
    parameter int DIV_WIDTH   = 8,
    localparam int ID_WIDTH   = $clog2(NB_CHANNELS)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             tick_in_i,
    input  logic [NB_CHANNELS-1:0]           enable_i,
    input  logic [NB_CHANNELS*DIV_WIDTH-1:0] period_div_i,
    output logic                             dispatch_valid_o,
    output logic [ID_WIDTH-1:0]              dispatch_id_o,
    input  logic                             dispatch_ready_i,
    output logic [NB_CHANNELS-1:0]           overrun_o,
    input  logic                             overrun_clear_i
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t                  state_q;
    logic                    valid_q;
    logic [ID_WIDTH-1:0]     id_q, last_q, pick;
    logic [NB_CHANNELS-1:0]  pending_q, pending_d, overrun_q, overrun_d;
    logic [NB_CHANNELS-1:0]  fire, acc_mask, ovr_set;
    logic                    found;
    int                      idx;

    tick_sched_lane #(.DIV_WIDTH(DIV_WIDTH)) u_lane [NB_CHANNELS-1:0] (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_i  (tick_in_i),
        .en_i    (enable_i),
        .div_i   (period_div_i),
        .fire_o  (fire)
    );

    // A fire coinciding with its own accept re-arms pending instead of overrunning
    always_comb begin
        acc_mask  = (valid_q && dispatch_ready_i) ? (NB_CHANNELS'(1) << id_q) : '0;
        ovr_set   = fire & pending_q & ~acc_mask;
        pending_d = fire | (pending_q & ~acc_mask);
        overrun_d = ovr_set | (overrun_q & ~{NB_CHANNELS{overrun_clear_i}});
    end

    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NB_CHANNELS; k++) begin
            idx = (int'(last_q) + k) % NB_CHANNELS;
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                pick  = ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            last_q    <= ID_WIDTH'(NB_CHANNELS - 1);
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: if (found) begin
                    id_q    <= pick;
                    valid_q <= 1'b1;
                    state_q <= OFFER;
                end
                OFFER: if (dispatch_ready_i) begin
                    last_q  <= id_q;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dispatch_valid_o = valid_q;
    assign dispatch_id_o    = id_q;
    assign overrun_o        = overrun_q;
endmodule
